// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time program loader: default widths,
// header size and the loader state encoding.
package rom_loader_pkg;

  localparam int IA_BITS       = 8;
  localparam int I_BITS        = 16;
  localparam int LDR_HDR_BYTES = 2;

  typedef enum logic [2:0] {
    LDR_CNT_LO = 3'd0,
    LDR_CNT_HI = 3'd1,
    LDR_WORD   = 3'd2,
    LDR_WRITE  = 3'd3,
    LDR_DONE   = 3'd4,
    LDR_ERR    = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream valid/ready channel feeding the loader; the source is the
// master, the loader the slave.
interface rom_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/rom_loader_word_packer.sv
// Byte-to-word shift register: bytes arrive least-significant first and are
// shifted in from the top; full_o flags the byte that completes a word.
module word_packer #(
  parameter int instr_width = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [7:0]             byte_i,
  output logic [instr_width-1:0] word_o,
  output logic                   full_o
);

  localparam int BYTES = instr_width / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]       cnt_q;
  logic [instr_width-1:0] word_q;
  logic [instr_width+7:0] shift_w;

  // word_o already contains the byte being accepted, so the loader can latch
  // the complete word on the same edge that takes the last byte.
  assign shift_w = {byte_i, word_q};
  assign word_o  = shift_w[instr_width+7:8];
  assign full_o  = valid_i && (cnt_q == CNT_W'(BYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
    end else if (valid_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      cnt_q  <= full_o ? '0 : cnt_q + CNT_W'(1);
      word_q <= word_o;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: parses a little-endian word-count header, packs the following
// bytes into instruction words, writes them from address 0 and then releases
// the core from reset.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int pc_width    = IA_BITS,
  parameter int instr_width = I_BITS
) (
  input  logic                   clk,
  input  logic                   rstn,
  rom_loader_if.slave            in_if,
  input  logic                   reload,
  output logic                   wr_en,
  output logic [pc_width-1:0]    wr_addr,
  output logic [instr_width-1:0] wr_data,
  output logic                   core_rstn,
  output logic                   done,
  output logic                   err
);

  localparam int          N_W      = 8 * LDR_HDR_BYTES;
  localparam logic [31:0] CAPACITY = 32'd1 << pc_width;

  ldr_state_e             state_q;
  logic [N_W-1:0]         n_q;
  logic [pc_width:0]      addr_q;
  logic [pc_width:0]      addr_d;
  logic                   wr_en_q;
  logic [pc_width-1:0]    wr_addr_q;
  logic [instr_width-1:0] wr_data_q;
  logic                   core_rstn_q;
  logic                   done_q;
  logic                   err_q;

  logic                   accept;
  logic [N_W-1:0]         n_hdr;
  logic [instr_width-1:0] packed_word;
  logic                   packed_full;

  assign in_if.in_ready = (state_q == LDR_CNT_LO) || (state_q == LDR_CNT_HI) ||
                          (state_q == LDR_WORD);
  assign accept = in_if.in_valid && in_if.in_ready;
  assign n_hdr  = {in_if.in_data, n_q[7:0]};
  // One extra address bit lets a full 2^pc_width program terminate cleanly.
  assign addr_d = addr_q + {{pc_width{1'b0}}, 1'b1};

  word_packer #(
    .instr_width(instr_width)
  ) u_packer (
    .clk    (clk),
    .rstn   (rstn),
    .clear_i(accept && (state_q == LDR_CNT_HI)),
    .valid_i(accept && (state_q == LDR_WORD)),
    .byte_i (in_if.in_data),
    .word_o (packed_word),
    .full_o (packed_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= LDR_CNT_LO;
      n_q         <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        LDR_CNT_LO: begin
          if (accept) begin
            n_q[7:0] <= in_if.in_data;
            state_q  <= LDR_CNT_HI;
          end
        end
        LDR_CNT_HI: begin
          if (accept) begin
            n_q[N_W-1:8] <= in_if.in_data;
            addr_q       <= '0;
            if (32'(n_hdr) > CAPACITY) begin
              state_q <= LDR_ERR;
              err_q   <= 1'b1;
            end else if (n_hdr == '0) begin
              state_q     <= LDR_DONE;
              done_q      <= 1'b1;
              core_rstn_q <= 1'b1;
            end else begin
              state_q <= LDR_WORD;
            end
          end
        end
        LDR_WORD: begin
          if (packed_full) begin
            state_q   <= LDR_WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q[pc_width-1:0];
            wr_data_q <= packed_word;
          end
        end
        LDR_WRITE: begin
          addr_q <= addr_d;
          if (32'(addr_d) == 32'(n_q)) begin
            state_q     <= LDR_DONE;
            done_q      <= 1'b1;
            core_rstn_q <= 1'b1;
          end else begin
            state_q <= LDR_WORD;
          end
        end
        LDR_DONE: begin
          if (reload) begin
            state_q     <= LDR_CNT_LO;
            done_q      <= 1'b0;
            core_rstn_q <= 1'b0;
          end
        end
        LDR_ERR: begin
          state_q <= LDR_ERR;
        end
        default: begin
          state_q <= LDR_CNT_LO;
        end
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_rstn = core_rstn_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader (pc_width=8, instr_width=16): header parsing,
// back-pressure, boundaries, reload and asynchronous reset behaviour.
module tb_rom_loader;

  localparam int PCW = 8;
  localparam int IW  = 16;

  logic           clk    = 1'b0;
  logic           rstn   = 1'b0;
  logic           reload = 1'b0;
  logic           wr_en;
  logic [PCW-1:0] wr_addr;
  logic [IW-1:0]  wr_data;
  logic           core_rstn;
  logic           done;
  logic           err;

  rom_loader_if u_if ();

  rom_loader #(
    .pc_width   (PCW),
    .instr_width(IW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_if    (u_if),
    .reload   (reload),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .core_rstn(core_rstn),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Write log filled on the falling edge, away from the active edge.
  int             wr_n = 0;
  logic [PCW-1:0] log_addr [0:511];
  logic [IW-1:0]  log_data [0:511];
  logic           log_rdy  [0:511];

  always @(negedge clk) begin
    if (wr_en && wr_n < 512) begin
      log_addr[wr_n] = wr_addr;
      log_data[wr_n] = wr_data;
      log_rdy[wr_n]  = u_if.in_ready;
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = b;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = u_if.in_ready;
      step();
    end
    u_if.in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
      send_byte(q[i]);
    end
  endtask

  task automatic check_writes(input int base, input logic [IW-1:0] exp_data[$]);
    int n;
    n = wr_n - base;
    check("wr_count", 32'(n), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < n; i++) begin
      check("wr_addr", 32'(log_addr[base+i]), 32'(i));
      check("wr_data", 32'(log_data[base+i]), 32'(exp_data[i]));
      check("rdy_in_write", 32'(log_rdy[base+i]), 32'd0);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  initial begin
    int             base;
    logic [IW-1:0]  exp_q[$];
    logic [7:0]     bytes_q[$];

    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;

    // Reset values
    #1;
    check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Three words, continuous valid
    base = wr_n;
    send_stream('{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC}, 0);
    send_byte(8'h9A);
    check("last_write_en", 32'(wr_en), 32'd1);
    check("last_write_rdy", 32'(u_if.in_ready), 32'd0);
    check("last_write_done", 32'(done), 32'd0);
    step();
    check("load3_done", 32'(done), 32'd1);
    check("load3_core_rstn", 32'(core_rstn), 32'd1);
    check_writes(base, '{16'h1234, 16'h5678, 16'h9ABC});

    // Reload drops done and core_rstn on the same edge; then back-pressured load
    pulse_reload();
    check("reload_done", 32'(done), 32'd0);
    check("reload_core_rstn", 32'(core_rstn), 32'd0);
    check("reload_in_ready", 32'(u_if.in_ready), 32'd1);
    base = wr_n;
    send_stream('{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 3);
    step();
    check("bp_done", 32'(done), 32'd1);
    check_writes(base, '{16'h2211, 16'h4433, 16'h6655});

    // One word, with a reload pulse during WORD that must be ignored
    pulse_reload();
    base = wr_n;
    send_stream('{8'h01, 8'h00, 8'hEF}, 0);
    pulse_reload();
    check("reload_in_word_rdy", 32'(u_if.in_ready), 32'd1);
    check("reload_in_word_done", 32'(done), 32'd0);
    send_byte(8'hBE);
    step();
    check("beef_done", 32'(done), 32'd1);
    check_writes(base, '{16'hBEEF});

    // N = 0: done directly after the second header byte, no writes
    pulse_reload();
    base = wr_n;
    send_stream('{8'h00, 8'h00}, 0);
    check("n0_done", 32'(done), 32'd1);
    check("n0_core_rstn", 32'(core_rstn), 32'd1);
    repeat (3) step();
    check("n0_wr_count", 32'(wr_n - base), 32'd0);

    // N = 256: fills the whole memory, last write at 0xFF
    pulse_reload();
    base = wr_n;
    exp_q = {};
    bytes_q = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      bytes_q.push_back(8'(i));
      bytes_q.push_back(8'(i) ^ 8'h5A);
      exp_q.push_back({8'(i) ^ 8'h5A, 8'(i)});
    end
    send_stream(bytes_q, 0);
    step();
    check("n256_done", 32'(done), 32'd1);
    check("n256_last_addr", 32'(log_addr[base+255]), 32'hFF);
    check_writes(base, exp_q);

    // N = 257: capacity exceeded, sticky error until rstn
    pulse_reload();
    send_stream('{8'h01, 8'h01}, 0);
    check("n257_err", 32'(err), 32'd1);
    check("n257_in_ready", 32'(u_if.in_ready), 32'd0);
    check("n257_core_rstn", 32'(core_rstn), 32'd0);
    pulse_reload();
    repeat (4) step();
    check("n257_err_sticky", 32'(err), 32'd1);
    check("n257_core_rstn_hold", 32'(core_rstn), 32'd0);
    rstn = 1'b0;
    #2;
    check("n257_rst_err", 32'(err), 32'd0);
    check("n257_rst_in_ready", 32'(u_if.in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Mid-load reset during the first WRITE, then a fresh full load
    send_stream('{8'h03, 8'h00, 8'h34, 8'h12}, 0);
    rstn = 1'b0;
    #2;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_in_ready", 32'(u_if.in_ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_core_rstn", 32'(core_rstn), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    base = wr_n;
    send_stream('{8'h03, 8'h00, 8'h01, 8'hA0, 8'h02, 8'hB0, 8'h03, 8'hC0}, 0);
    step();
    check("fresh_done", 32'(done), 32'd1);
    check_writes(base, '{16'hA001, 16'hB002, 16'hC003});

    // Reset while DONE drops core_rstn without waiting for a clock edge
    #2;
    rstn = 1'b0;
    #1;
    check("done_rst_core_rstn", 32'(core_rstn), 32'd0);
    check("done_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader: the write side of the instruction memory that the core only fetches from. It receives a byte stream over a valid/ready handshake, assembles instruction words and writes them sequentially into a writable instruction memory from address 0. It holds the core in reset until the whole program is written, then releases it. It sits between an external byte source (UART receiver, test bench, debug port) and the core's instruction memory and reset input.

## Interface
- `pc_width`, default `IA_BITS`, instruction-address width; the program holds at most 2^pc_width words.
- `instr_width`, default `I_BITS`, instruction width; must be a multiple of 8.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `reload`  in  1  single-cycle request to load a new program; honoured only in DONE.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  pc_width  word address being written.
- `wr_data`  out  instr_width  assembled word.
- `core_rstn`  out  1  active-low reset to the core; high only in DONE.
- `done`  out  1  program loaded and core released.
- `err`  out  1  the header word count exceeded capacity; sticky until `rstn`.

## Operation
- Stream format:
  - 2-byte header N (word count, little-endian).
  - Then N words, each sent as instr_width/8 bytes, least-significant byte first.
- A byte transfers on a rising edge with `in_valid && in_ready`.
- States and transitions:
  - CNT_LO: accept byte → N[7:0]; go to CNT_HI.
  - CNT_HI: accept byte → N[15:8]. Next state:
    - ERR if N > 2^pc_width;
    - DONE if N = 0;
    - otherwise WORD, with the address counter and byte counter cleared.
  - WORD: shift each accepted byte into the word register. After byte instr_width/8 is accepted, go to WRITE.
  - WRITE: `wr_en`=1 for one cycle with the current `wr_addr` and `wr_data`; the address counter increments. Next state is DONE if the incremented count = N, otherwise WORD.
  - DONE: `core_rstn`=1, `done`=1. `reload`=1 → CNT_LO; `core_rstn` and `done` drop on the same edge.
  - ERR: `err`=1, `core_rstn`=0. Exited only by `rstn`.
- `in_ready` = 1 exactly in CNT_LO, CNT_HI and WORD; it is decoded from the state.
- The address counter is pc_width+1 bits internally, so N = 2^pc_width is legal. `wr_addr` never wraps.
- `reload` in any state other than DONE is ignored.
- Bytes offered while `in_ready`=0 are not consumed; the source must hold them.

## Timing
- Reset values: state CNT_LO, `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_rstn`=0, `done`=0, `err`=0.
- `rstn` asserted mid-load aborts immediately. `core_rstn` goes low asynchronously, and the partial program is discarded (the loader restarts at the header).
- `wr_en`, `wr_addr` and `wr_data` are registered. The word's last byte is accepted at edge t; the write occurs in cycle t..t+1 and `in_ready`=0 during it.
- Throughput: one word per (instr_width/8 + 1) cycles with continuous `in_valid`.
- The last word's WRITE cycle is followed on the next edge by `done`=1 and `core_rstn`=1.
- N = 0: `done` rises one edge after the CNT_HI byte is accepted.
- `wr_data` holds its value outside WRITE; only `wr_en` qualifies it.

## Structure
- Add to `defs.vh`:
  - state encodings `LDR_CNT_LO`, `LDR_CNT_HI`, `LDR_WORD`, `LDR_WRITE`, `LDR_DONE`, `LDR_ERR`;
  - `LDR_HDR_BYTES` = 2.
- One natural sub-module, `word_packer`: a byte-to-word shift register with byte counter and `full` flag, parameterised by `instr_width`.
- The FSM, address counter and N register stay in `rom_loader`.

## Test plan
- Load 3 words: pc_width=8, instr_width=16, stream 03 00 34 12 78 56 BC 9A with continuous valid → writes 0x1234@0, 0x5678@1, 0x9ABC@2. Then `done`=1, `core_rstn`=1, and exactly 3 `wr_en` pulses.
- Back-pressure: a random `in_valid` gap pattern gives the same writes and no dropped or duplicated bytes. `in_ready`=0 in every WRITE cycle.
- Boundaries:
  - N=0 (00 00) → `done` one edge after the second byte, with no writes.
  - N=256 with pc_width=8 → the last write goes to 0xFF, then DONE.
  - N=257 → `err`=1, `in_ready`=0 and `core_rstn` stays 0 until `rstn`.
- Reload: after DONE, pulse `reload` → `core_rstn`=0 and `done`=0 on the same edge. A new 1-word stream 01 00 EF BE writes 0xBEEF@0. A `reload` pulse during WORD has no effect.
- Mid-load reset: drop `rstn` after the 2nd data byte → all outputs at reset values asynchronously. A full fresh stream afterward loads correctly from address 0.
